// File: rtl/mycpu_pkg.sv
// Shared types and constants for the 16-bit CPU.
// The instruction fetch unit takes its FSM state type and its parameter
// defaults from here.
package mycpu_pkg;

    // Fetch FSM: wait for a request, hold the memory read, strobe the IR.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } ifetch_state_t;

    localparam logic [15:0] IFETCH_RESET_PC = 16'h0000;
    localparam int          IFETCH_TIMEOUT  = 15;

    // Sequential PC advance. The PC wraps modulo 2^16, so 16'hFFFF is
    // followed by 16'h0000.
    function automatic logic [15:0] ifetch_pc_inc(input logic [15:0] pc);
        return pc + 16'h0001;
    endfunction

endpackage

// File: rtl/ifetch_wdog.sv
// Fetch watchdog. It counts REQ cycles that end without an acknowledge and
// flags the edge on which the fetch must be abandoned.
// It is instantiated by ifetch only when IFETCH_TIMEOUT_EN is defined.
module ifetch_wdog
    import mycpu_pkg::*;
#(
    parameter int TIMEOUT = IFETCH_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,   // FSM is in REQ
    input  logic i_ack,      // memory acknowledge this cycle
    output logic o_expire    // abort at the coming edge
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    // The abort edge is the TIMEOUT-th unacknowledged REQ edge. At that
    // edge TIMEOUT-1 misses have already been counted.
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count misses while in REQ. The counter is held at zero outside REQ,
    // so every new request starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_active) begin
            r_count <= '0;
        end else if (!i_ack) begin
            r_count <= r_count + CW'(1);
        end
    end

    // An acknowledge on the limit edge wins over the timeout.
    assign o_expire = i_active && !i_ack && (r_count == LAST);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit. It reads one word per request through a
// valid/acknowledge handshake, strobes the word into the IR for one
// cycle, and owns the program counter.
// Optional feature: define IFETCH_TIMEOUT_EN to abort a fetch after
// TIMEOUT unacknowledged REQ cycles. The abort is reported on
// fetch_err_out.
module ifetch
    import mycpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = IFETCH_RESET_PC,
    parameter int          TIMEOUT  = IFETCH_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_in,
    input  logic        pc_load_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_rdata_in,
    input  logic        mem_ack_in,
    output logic [15:0] mem_addr_out,
    output logic        mem_rd_out,
    output logic [15:0] ins_out,
    output logic        il_out,
    output logic [15:0] pc_out,
    output logic        busy_out,
    output logic        fetch_err_out
);

    ifetch_state_t r_state;
    ifetch_state_t w_state_next;
    logic [15:0]   r_pc;
    logic [15:0]   w_pc_next;
    logic [15:0]   r_ins;
    logic [15:0]   w_ins_next;
    logic          w_err_next;
    logic          w_expire;

    // A TIMEOUT below 1 would make the watchdog abort before the first
    // REQ edge. That is not a meaningful configuration.
    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
        end
    endgenerate

`ifdef IFETCH_TIMEOUT_EN
    logic r_err;

    ifetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_active (r_state == REQ),
        .i_ack    (mem_ack_in),
        .o_expire (w_expire)
    );

    // Register the one-cycle error pulse that follows an aborted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign fetch_err_out = r_err;
`else
    // Without the watchdog, REQ waits for as long as it takes.
    assign w_expire      = 1'b0;
    assign fetch_err_out = 1'b0;
`endif

    // Update the state, PC and instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_ins   <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ins   <= w_ins_next;
        end
    end

    // Compute next state. The PC and the instruction change only on a
    // branch load in IDLE or on an acknowledged REQ edge.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ins_next   = r_ins;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                // A branch load beats a fetch request at the same edge.
                // The fetch is dropped, not deferred.
                if (pc_load_in) begin
                    w_pc_next = pc_in;
                end else if (fetch_in) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack_in) begin
                    w_ins_next   = mem_rdata_in;
                    w_pc_next    = ifetch_pc_inc(r_pc);
                    w_state_next = LOAD;
                end else if (w_expire) begin
                    w_state_next = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            LOAD: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Every handshake and strobe output is decoded from registers only,
    // so no input reaches an output combinationally.
    assign mem_rd_out   = (r_state == REQ);
    assign il_out       = (r_state == LOAD);
    assign busy_out     = (r_state == REQ) || (r_state == LOAD);
    assign mem_addr_out = r_pc;
    assign pc_out       = r_pc;
    assign ins_out      = r_ins;

endmodule
